// File: rtl/shiftreg_pkg.sv
// Shared definitions for the LED sequencer: FSM encodings, switch bit
// positions and the one-hot colour bank constants.
package shiftreg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Bit positions inside the switch word
   localparam int SW_RUN     = 0;
   localparam int SW_RATE_LO = 1;
   localparam int SW_RATE_HI = 2;
   localparam int SW_MODE    = 3;

   // One-hot LED bank enables
   localparam logic [2:0] COLOR_R = 3'b001;
   localparam logic [2:0] COLOR_B = 3'b010;
   localparam logic [2:0] COLOR_G = 3'b100;

   // Advance the colour bank: 001 -> 010 -> 100 -> 001
   function automatic logic [2:0] next_color(input logic [2:0] c);
      return {c[1:0], c[2]};
   endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Switch inputs and sequencer outputs of led_seq_ctrl bundled as one
// interface. The master drives the switches and observes the outputs;
// the slave is the sequencer side.
interface led_seq_ctrl_if #(
   parameter int NB_SW = 4
);
   logic [NB_SW-1:0] sw;
   logic             load;
   logic             shift_en;
   logic             dir;
   logic [2:0]       color;
   logic [1:0]       state;

   modport master (output sw, input load, input shift_en, input dir, input color, input state);
   modport slave  (input sw, output load, output shift_en, output dir, output color, output state);
endinterface

// File: rtl/tick_gen.sv
// Prescaler with terminal-count compare. The tick is asserted while enabled
// and the count has reached or passed the limit, so lowering the limit
// below the current count yields a tick on the very next enabled cycle.
module tick_gen #(
   parameter int NB_COUNTER = 14
) (
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_clear,
   input  logic [NB_COUNTER-1:0] i_limit,
   output logic                  o_tick
);

   logic [NB_COUNTER-1:0] cnt_q, cnt_d;

   assign o_tick = i_enable && (cnt_q >= i_limit);

   // Next count: clear wins, a tick restarts the period, otherwise count while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear || o_tick) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = cnt_q + NB_COUNTER'(1);
      end
   end

   // Prescaler register, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: synchronises the switches, runs an
// IDLE/LOAD/RUN/HOLD FSM and emits registered load/shift pulses, shift
// direction and a colour bank that advances each time a pass completes.
module led_seq_ctrl
   import shiftreg_pkg::*;
#(
   parameter int NB_LEDS    = 4,
   parameter int NB_SW      = 4,
   parameter int NB_COUNTER = 14,
   parameter int LIMIT_0    = 1023,
   parameter int LIMIT_1    = 511,
   parameter int LIMIT_2    = 255,
   parameter int LIMIT_3    = 127
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_sw,
   output logic             o_load,
   output logic             o_shift_en,
   output logic             o_dir,
   output logic [2:0]       o_color,
   output logic [1:0]       o_state
);

   localparam int NB_POS = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
   localparam logic [NB_POS-1:0] LAST_POS = NB_POS'(NB_LEDS - 1);

   logic [NB_SW-1:0]      sw_meta_q, sw_sync_q;
   logic                  run, mode;
   logic [1:0]            rate;
   state_e                state_q, state_d;
   logic [NB_POS-1:0]     pos_q, pos_d, new_pos;
   logic                  dir_q, dir_d, step_dir;
   logic                  load_q, load_d, shift_q, shift_d, odir_q, odir_d;
   logic [2:0]            color_q, color_d;
   logic [NB_COUNTER-1:0] limit_sel;
   logic                  tg_en, tg_clr, tick;

   // Two-flop synchroniser for the asynchronous switches
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= i_sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign run  = sw_sync_q[SW_RUN];
   assign mode = sw_sync_q[SW_MODE];
   assign rate = sw_sync_q[SW_RATE_HI:SW_RATE_LO];

   // Rate select is combinational so a change applies immediately
   always_comb begin
      unique case (rate)
         2'd0:    limit_sel = NB_COUNTER'(LIMIT_0);
         2'd1:    limit_sel = NB_COUNTER'(LIMIT_1);
         2'd2:    limit_sel = NB_COUNTER'(LIMIT_2);
         default: limit_sel = NB_COUNTER'(LIMIT_3);
      endcase
   end

   assign tg_en  = (state_q == ST_RUN) && run;
   assign tg_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

   tick_gen #(
      .NB_COUNTER (NB_COUNTER)
   ) u_tick_gen (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (tg_en),
      .i_clear  (tg_clr),
      .i_limit  (limit_sel),
      .o_tick   (tick)
   );

   // FSM state register
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (run)  state_d = ST_LOAD;
         ST_LOAD:           state_d = ST_RUN;
         ST_RUN:  if (!run) state_d = ST_HOLD;
         ST_HOLD: if (run)  state_d = ST_RUN;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Output and position logic; direction at the ends is forced so a
   // switch into ping-pong at the last LED bounces instead of overrunning
   always_comb begin
      pos_d    = pos_q;
      dir_d    = dir_q;
      odir_d   = odir_q;
      color_d  = color_q;
      shift_d  = 1'b0;
      load_d   = (state_q == ST_IDLE) && (state_d == ST_LOAD);
      step_dir = 1'b0;
      new_pos  = pos_q;
      if (mode) begin
         if (pos_q == LAST_POS)  step_dir = 1'b1;
         else if (pos_q == '0)   step_dir = 1'b0;
         else                    step_dir = dir_q;
      end
      if (step_dir)              new_pos = pos_q - NB_POS'(1);
      else if (pos_q == LAST_POS) new_pos = '0;
      else                       new_pos = pos_q + NB_POS'(1);

      if (state_q == ST_LOAD) begin
         pos_d = '0;
         dir_d = 1'b0;
      end else if (tick) begin
         shift_d = 1'b1;
         odir_d  = step_dir;
         pos_d   = new_pos;
         if (!mode)                   dir_d = 1'b0;
         else if (new_pos == LAST_POS) dir_d = 1'b1;
         else if (new_pos == '0)      dir_d = 1'b0;
         else                         dir_d = step_dir;
         if (new_pos == '0) color_d = next_color(color_q);
      end
   end

   // Registered position, direction and outputs
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         pos_q   <= '0;
         dir_q   <= 1'b0;
         load_q  <= 1'b0;
         shift_q <= 1'b0;
         odir_q  <= 1'b0;
         color_q <= COLOR_R;
      end else begin
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         load_q  <= load_d;
         shift_q <= shift_d;
         odir_q  <= odir_d;
         color_q <= color_d;
      end
   end

   assign o_load     = load_q;
   assign o_shift_en = shift_q;
   assign o_dir      = odir_q;
   assign o_color    = color_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios followed by
// random switch activity, compared every cycle against a behavioural model.
module tb_led_seq_ctrl;

   localparam int NLED = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   led_seq_ctrl_if #(.NB_SW(4)) bus ();

   led_seq_ctrl #(
      .NB_LEDS    (NLED),
      .NB_SW      (4),
      .NB_COUNTER (14),
      .LIMIT_0    (7),
      .LIMIT_1    (5),
      .LIMIT_2    (3),
      .LIMIT_3    (1)
   ) dut (
      .clock      (clk),
      .i_reset    (rst_n),
      .i_sw       (bus.sw),
      .o_load     (bus.load),
      .o_shift_en (bus.shift_en),
      .o_dir      (bus.dir),
      .o_color    (bus.color),
      .o_state    (bus.state)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   int         lim [4] = '{7, 5, 3, 1};
   logic [3:0] s1, s2;
   int         ph, cnt, pos;
   logic       mdir;
   logic       e_load, e_shift, e_dir;
   logic [2:0] e_color;

   // Advance the model by one rising edge using the inputs present at it
   task automatic model_step();
      logic d;
      int   np;
      if (!rst_n) begin
         s1 = 0; s2 = 0; ph = 0; cnt = 0; pos = 0; mdir = 0;
         e_load = 0; e_shift = 0; e_dir = 0; e_color = 3'b001;
         return;
      end
      e_load  = 0;
      e_shift = 0;
      case (ph)
         0: begin
            cnt = 0;
            if (s2[0]) begin ph = 1; e_load = 1; end
         end
         1: begin ph = 2; pos = 0; mdir = 0; cnt = 0; end
         2: begin
            if (!s2[0]) ph = 3;
            else if (cnt >= lim[s2[2:1]]) begin
               cnt = 0;
               if (!s2[3]) begin
                  d = 0; np = (pos + 1) % NLED; mdir = 0;
               end else begin
                  d = (pos == NLED-1) ? 1'b1 : (pos == 0) ? 1'b0 : mdir;
                  np = d ? pos - 1 : pos + 1;
                  mdir = (np == NLED-1) ? 1'b1 : (np == 0) ? 1'b0 : d;
               end
               pos = np;
               e_shift = 1;
               e_dir = d;
               if (np == 0) e_color = {e_color[1:0], e_color[2]};
            end else cnt++;
         end
         default: if (s2[0]) ph = 2;
      endcase
      s2 = s1;
      s1 = bus.sw;
   endtask

   // Run n cycles, comparing every output against the model mid-cycle
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         cycle++;
         @(negedge clk);
         checks++;
         assert (bus.state === 2'(ph)) else begin
            errors++; $error("FAIL state: got %0d expected %0d cycle %0d", bus.state, ph, cycle);
         end
         checks++;
         assert (bus.load === e_load) else begin
            errors++; $error("FAIL load: got %0b expected %0b cycle %0d", bus.load, e_load, cycle);
         end
         checks++;
         assert (bus.shift_en === e_shift) else begin
            errors++; $error("FAIL shift_en: got %0b expected %0b cycle %0d", bus.shift_en, e_shift, cycle);
         end
         checks++;
         assert (bus.color === e_color) else begin
            errors++; $error("FAIL color: got %b expected %b cycle %0d", bus.color, e_color, cycle);
         end
         checks++;
         assert (!(bus.load === 1'b1 && bus.shift_en === 1'b1)) else begin
            errors++; $error("FAIL exclusive: load %0b shift_en %0b expected not both cycle %0d", bus.load, bus.shift_en, cycle);
         end
         if (e_shift) begin
            checks++;
            assert (bus.dir === e_dir) else begin
               errors++; $error("FAIL dir: got %0b expected %0b cycle %0d", bus.dir, e_dir, cycle);
            end
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      bus.sw = 4'b0000;
      cyc(10);
      rst_n = 1'b1;
      cyc(5);
      // rotate at slowest rate
      bus.sw = 4'b0001;
      cyc(45);
      // fastest rate while running
      bus.sw = 4'b0111;
      cyc(20);
      bus.sw = 4'b0011;
      cyc(20);
      bus.sw = 4'b0001;
      cyc(20);
      // ping-pong
      bus.sw = 4'b1001;
      cyc(80);
      bus.sw = 4'b1111;
      cyc(30);
      // back to rotate, then hold and resume
      bus.sw = 4'b0111;
      cyc(20);
      bus.sw = 4'b0000;
      cyc(20);
      bus.sw = 4'b0001;
      cyc(40);
      // one-cycle reset mid-run
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(30);
      // random switch activity with occasional resets
      for (int k = 0; k < 300; k++) begin
         bus.sw = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            cyc(1);
            rst_n = 1'b1;
         end
         cyc($urandom_range(1, 25));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter NB_LEDS, default 4, number of LED positions sequenced.
REQ-002 SHALL have parameter NB_SW, default 4, switch input width.
REQ-003 SHALL have parameter NB_COUNTER, default 14, prescaler counter width.
REQ-004 SHALL have parameters LIMIT_0..LIMIT_3, defaults 1023/511/255/127, prescaler terminal counts; each SHALL fit in NB_COUNTER bits.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port i_sw, input, NB_SW, asynchronous switches: [0] run, [2:1] rate select, [3] mode (0 rotate, 1 ping-pong).
REQ-008 SHALL have port o_load, output, 1, one-cycle pulse: shift register loads seed (position 0 lit).
REQ-009 SHALL have port o_shift_en, output, 1, one-cycle pulse: shift register shifts one place.
REQ-010 SHALL have port o_dir, output, 1, shift direction (0 toward higher index, 1 toward lower), valid whenever o_shift_en=1.
REQ-011 SHALL have port o_color, output, 3, one-hot LED bank enable: [0] o_led, [1] o_led_b, [2] o_led_g.
REQ-012 SHALL have port o_state, output, 2, current FSM state, for debug.

Function
REQ-013 SHALL pass i_sw through a 2-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-014 SHALL implement FSM IDLE(0), LOAD(1), RUN(2), HOLD(3).
REQ-015 IDLE: prescaler held at 0, no pulses; run=1 -> LOAD.
REQ-016 LOAD: o_load=1 for exactly that cycle; position<=0, dir<=0, prescaler<=0; next state RUN unconditionally.
REQ-017 RUN: prescaler increments each cycle; when prescaler >= LIMIT_sel, prescaler<=0 and o_shift_en=1 that cycle (tick period LIMIT_sel+1 cycles); run=0 -> HOLD, and no tick is issued in that cycle.
REQ-018 HOLD: prescaler and position frozen, no pulses; run=1 -> RUN, resuming without reload.
REQ-019 Rate change SHALL take effect immediately; the >= compare guarantees a tick on the next cycle if prescaler already exceeds the new limit.
REQ-020 Rotate mode: on tick position<=(position+1) mod NB_LEDS, o_dir=0.
REQ-021 Ping-pong mode: on tick position moves per o_dir; if new position = NB_LEDS-1, dir<=1; if new position = 0, dir<=0.
REQ-022 Mode change to rotate SHALL force dir<=0 at the next tick; change to ping-pong continues from the current position with dir=0 unless position = NB_LEDS-1.
REQ-023 A pass SHALL complete when a tick moves position to 0 (rotate wrap, or ping-pong return); o_color SHALL then rotate 001->010->100->001.
REQ-024 o_load and o_shift_en SHALL never be asserted in the same cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 With i_reset=0 at a rising edge: state IDLE, prescaler 0, position 0, dir 0, synchronizer flops 0, o_load 0, o_shift_en 0, o_dir 0, o_color 3'b001, o_state 0.
REQ-027 Reset asserted mid-RUN SHALL abort the sequence; no pulse SHALL be issued in the reset cycle.

Structure
REQ-028 Package shiftreg_pkg SHALL hold FSM state encodings, switch bit indices, and color one-hot constants.
REQ-029 Prescaler plus terminal-count compare SHALL be sub-module tick_gen (inputs enable, clear, limit; output tick).

Verification
REQ-030 Bench SHALL override LIMIT_0..3 = 7/5/3/1 for runtime.
REQ-031 Reset low 10 cycles, i_sw=0000 -> o_state=0, o_color=001, no pulses.
REQ-032 i_sw=0001 -> o_load one cycle (3 cycles after change), then o_shift_en every 8 cycles; o_dir=0; o_color=010 after 4th tick.
REQ-033 i_sw=0111 while running -> tick period 2 cycles from the next tick.
REQ-034 i_sw=1001 -> tick directions 0,0,0,1,1,1 repeating; o_color advances on each return to position 0.
REQ-035 i_sw 0001->0000 for 20 cycles ->0001 -> no pulses during HOLD, no o_load on resume, position continues.
REQ-036 i_reset low for 1 cycle mid-RUN -> outputs at reset values next cycle; restart begins with o_load.
